// File: rtl/ula_muldiv.sv
// Iterative radix-2 multiply/divide unit for the RISC-V M extension.
// One shift-add or restoring-division step per clock, with a start/busy/done handshake.
module ula_muldiv #(
  parameter int unsigned SIZE = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [SIZE-1:0] s1,
  input  logic [SIZE-1:0] s2,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] res
);

  localparam int unsigned CntW = $clog2(SIZE + 1);
  localparam logic [SIZE-1:0] MinNeg = {1'b1, {(SIZE-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      op_q;
  logic            neg_q;
  logic            rneg_q;
  logic [SIZE-1:0] hi_q;
  logic [SIZE-1:0] lo_q;
  logic [SIZE-1:0] den_q;
  logic            busy_q;
  logic            done_q;
  logic [SIZE-1:0] res_q;

  // Operand decode at accept
  logic            s1_signed, s2_signed, s1_neg, s2_neg;
  logic [SIZE-1:0] s1_mag, s2_mag;
  logic            div_zero, div_ovf, special;
  logic [SIZE-1:0] special_res;

  always_comb begin
    // s1 signed for MUL/MULH/MULHSU/DIV/REM, s2 signed for MUL/MULH/DIV/REM
    s1_signed   = ~op[0] | (op[2:1] == 2'b00);
    s2_signed   = op[2] ? ~op[0] : ~op[1];
    s1_neg      = s1_signed & s1[SIZE-1];
    s2_neg      = s2_signed & s2[SIZE-1];
    s1_mag      = s1_neg ? -s1 : s1;
    s2_mag      = s2_neg ? -s2 : s2;
    div_zero    = (s2 == '0);
    div_ovf     = ~op[0] & (s1 == MinNeg) & (&s2);
    special     = op[2] & (div_zero | div_ovf);
    special_res = div_zero ? (op[1] ? s1 : '1) : (op[1] ? '0 : s1);
  end

  // One iteration of either datapath
  logic [SIZE:0]   mul_sum, div_sh, div_diff;
  logic            div_ge;
  logic [SIZE-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, den_q} : '0);
    div_sh   = {hi_q, lo_q[SIZE-1]};
    div_diff = div_sh - {1'b0, den_q};
    // Partial remainder stays below the divisor, so bit SIZE is a clean borrow flag
    div_ge   = ~div_diff[SIZE];
    if (op_q[2]) begin
      step_hi = div_ge ? div_diff[SIZE-1:0] : div_sh[SIZE-1:0];
      step_lo = {lo_q[SIZE-2:0], div_ge};
    end else begin
      step_hi = mul_sum[SIZE:1];
      step_lo = {mul_sum[0], lo_q[SIZE-1:1]};
    end
  end

  // Sign restoration and result selection
  logic [2*SIZE-1:0] prod_mag, prod;
  logic [SIZE-1:0]   quot, rem, fix_res;

  always_comb begin
    prod_mag = {hi_q, lo_q};
    prod     = neg_q ? -prod_mag : prod_mag;
    quot     = neg_q ? -lo_q : lo_q;
    rem      = rneg_q ? -hi_q : hi_q;
    case (op_q)
      3'b000:                 fix_res = prod[SIZE-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*SIZE-1:SIZE];
      3'b100, 3'b101:         fix_res = quot;
      default:                fix_res = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      den_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            op_q <= op;
            if (special) begin
              res_q   <= special_res;
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              hi_q    <= '0;
              lo_q    <= op[2] ? s1_mag : s2_mag;
              den_q   <= op[2] ? s2_mag : s1_mag;
              neg_q   <= s1_neg ^ s2_neg;
              rneg_q  <= s1_neg;
              cnt_q   <= CntW'(SIZE);
              state_q <= StCalc;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= StIdle;
            done_q  <= 1'b0;
          end
        end
        StCalc: begin
          hi_q  <= step_hi;
          lo_q  <= step_lo;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          res_q   <= fix_res;
          state_q <= StDone;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign res  = res_q;

endmodule

// File: tb/tb_ula_muldiv.sv
// Bench for ula_muldiv: directed 64-bit cases plus 8-bit corner and random runs
// checked against an integer reference model through a result scoreboard.
module tb_ula_muldiv;

  logic        clk;
  logic        rst;
  logic        start64, start8;
  logic [2:0]  op64, op8;
  logic [63:0] s1_64, s2_64, res64;
  logic [7:0]  s1_8, s2_8, res8;
  logic        busy64, done64, busy8, done8;

  int n_tests;
  int n_fail;
  logic [63:0] exp_q[$];

  ula_muldiv #(.SIZE(64)) u_dut64 (
    .clk  (clk),
    .rst  (rst),
    .start(start64),
    .op   (op64),
    .s1   (s1_64),
    .s2   (s2_64),
    .busy (busy64),
    .done (done64),
    .res  (res64)
  );

  ula_muldiv #(.SIZE(8)) u_dut8 (
    .clk  (clk),
    .rst  (rst),
    .start(start8),
    .op   (op8),
    .s1   (s1_8),
    .s2   (s2_8),
    .busy (busy8),
    .done (done8),
    .res  (res8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model8(input logic [2:0] o, input logic [7:0] a,
                                        input logic [7:0] b);
    longint sa, sb, ua, ub, p;
    logic [7:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    p  = 0;
    case (o)
      3'd0: begin p = sa * sb; r = p[7:0]; end
      3'd1: begin p = sa * sb; r = p[15:8]; end
      3'd2: begin p = sa * ub; r = p[15:8]; end
      3'd3: begin p = ua * ub; r = p[15:8]; end
      3'd4: r = (b == 8'h00) ? 8'hFF : 8'(sa / sb);
      3'd5: r = (b == 8'h00) ? 8'hFF : 8'(ua / ub);
      3'd6: r = (b == 8'h00) ? a : 8'(sa % sb);
      default: r = (b == 8'h00) ? a : 8'(ua % ub);
    endcase
    return r;
  endfunction

  task automatic do_op64(input string tag, input logic [2:0] o, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp_r, input int exp_lat);
    int lat;
    logic [63:0] e;
    exp_q.push_back(exp_r);
    op64 = o; s1_64 = a; s2_64 = b; start64 = 1'b1;
    lat = 0;
    while (!done64 && lat < 200) begin
      tick();
      start64 = 1'b0;
      lat++;
    end
    e = exp_q.pop_front();
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check(tag, res64, e);
    tick();
    check({tag, "_pulse"}, 64'(done64), 64'd0);
    check({tag, "_hold"}, res64, e);
  endtask

  task automatic do_op8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    int lat, exp_lat;
    logic [63:0] e;
    exp_q.push_back(64'(model8(o, a, b)));
    exp_lat = (o[2] && (b == 8'h00 || (!o[0] && a == 8'h80 && b == 8'hFF))) ? 1 : 10;
    op8 = o; s1_8 = a; s2_8 = b; start8 = 1'b1;
    lat = 0;
    while (!done8 && lat < 50) begin
      tick();
      start8 = 1'b0;
      lat++;
    end
    e = exp_q.pop_front();
    check($sformatf("w8_op%0d_%h_%h_lat", o, a, b), 64'(lat), 64'(exp_lat));
    check($sformatf("w8_op%0d_%h_%h", o, a, b), 64'(res8), e);
    tick();
    check("w8_pulse", 64'(done8), 64'd0);
  endtask

  initial begin
    logic [7:0]  corners [5];
    logic [63:0] r;
    int lat, ndone;

    n_tests = 0;
    n_fail  = 0;
    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    start64 = 1'b1; op64 = 3'd0; s1_64 = 64'd3; s2_64 = 64'd5;
    start8  = 1'b1; op8  = 3'd0; s1_8  = 8'd3;  s2_8  = 8'd5;

    // Reset with start held high: rst must dominate
    rst = 1'b1;
    tick();
    check("rst_done_0", 64'(done64), 64'd0);
    tick();
    check("rst_done_1", 64'(done64), 64'd0);
    rst = 1'b0; start64 = 1'b0; start8 = 1'b0;
    tick();
    check("rst_busy", 64'(busy64), 64'd0);
    check("rst_done", 64'(done64), 64'd0);
    check("rst_res", res64, 64'd0);
    check("rst_res8", 64'(res8), 64'd0);

    // Multiply
    do_op64("mul", 3'b000, -64'sd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, 66);
    do_op64("mulh", 3'b001, -64'sd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    do_op64("mulhu", 3'b011, -64'sd3, 64'd7, 64'd6, 66);
    do_op64("mulh_m1m1", 3'b001, '1, '1, 64'd0, 66);
    do_op64("mulhsu_m1m1", 3'b010, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    do_op64("mulhu_m1m1", 3'b011, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66);

    // Divide / remainder
    do_op64("div", 3'b100, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    do_op64("rem", 3'b110, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    do_op64("divu", 3'b101, -64'sd7, 64'd2, 64'h7FFF_FFFF_FFFF_FFFC, 66);
    do_op64("remu", 3'b111, -64'sd7, 64'd2, 64'd1, 66);
    do_op64("div_pn", 3'b100, 64'd100, -64'sd7, -64'sd14, 66);
    do_op64("rem_pn", 3'b110, 64'd100, -64'sd7, 64'd2, 66);

    // Special cases
    do_op64("divu_z", 3'b101, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    do_op64("rem_z", 3'b110, 64'd5, 64'd0, 64'd5, 1);
    do_op64("div_z", 3'b100, -64'sd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    do_op64("remu_z", 3'b111, 64'd5, 64'd0, 64'd5, 1);
    do_op64("div_ovf", 3'b100, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    do_op64("rem_ovf", 3'b110, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
    do_op64("divu_noovf", 3'b101, 64'h8000_0000_0000_0000, '1, 64'd0, 66);

    // Start re-pulsed mid-CALC is ignored
    exp_q.push_back(64'd42);
    op64 = 3'b000; s1_64 = 64'd6; s2_64 = 64'd7; start64 = 1'b1;
    tick();
    start64 = 1'b0;
    repeat (10) tick();
    check("restart_busy", 64'(busy64), 64'd1);
    op64 = 3'b000; s1_64 = 64'd100; s2_64 = 64'd100; start64 = 1'b1;
    tick();
    start64 = 1'b0;
    ndone = 0;
    r = '0;
    for (int i = 0; i < 100; i++) begin
      if (done64) begin
        ndone++;
        r = res64;
      end
      tick();
    end
    check("restart_ndone", 64'(ndone), 64'd1);
    check("restart_res", r, exp_q.pop_front());

    // Back-to-back: start held in the DONE cycle
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    op64 = 3'b011; s1_64 = '1; s2_64 = '1; start64 = 1'b1;
    lat = 0;
    while (!done64 && lat < 200) begin
      tick();
      lat++;
    end
    check("b2b_first", res64, exp_q.pop_front());
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFD);
    op64 = 3'b100; s1_64 = -64'sd7; s2_64 = 64'd2;
    tick();
    start64 = 1'b0;
    check("b2b_done_drop", 64'(done64), 64'd0);
    check("b2b_busy", 64'(busy64), 64'd1);
    lat = 1;
    while (!done64 && lat < 200) begin
      tick();
      lat++;
    end
    check("b2b_lat", 64'(lat), 64'd66);
    check("b2b_second", res64, exp_q.pop_front());
    tick();
    check("b2b_pulse", 64'(done64), 64'd0);

    // Reset mid-CALC aborts without done
    op64 = 3'b000; s1_64 = 64'd9; s2_64 = 64'd9; start64 = 1'b1;
    tick();
    start64 = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(busy64), 64'd0);
    check("abort_done", 64'(done64), 64'd0);
    check("abort_res", res64, 64'd0);
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      if (done64) ndone++;
      tick();
    end
    check("abort_ndone", 64'(ndone), 64'd0);

    // 8-bit: every op over corner operand pairs, then random operands
    for (int o = 0; o < 8; o++) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          do_op8(3'(o), corners[i], corners[j]);
        end
      end
    end
    for (int k = 0; k < 300; k++) begin
      do_op8(3'($urandom_range(0, 7)), 8'($urandom()), 8'($urandom()));
    end

    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
